break_mask_fetch: RTL and testbench

//   Downstream consumer of the address translation table in the flip-evaluation path.
//   For one literal per request, it reads the ATT entry and fetches the clause-table word at the returned address.
//   It ANDs that word with the ATT mask to form the per-clause break vector, counts its set bits and returns both.

---
 rtl/break_mask_fetch_pkg.sv | 24 ++
 rtl/break_mask_fetch_if.sv | 46 ++++
 rtl/break_mask_fetch_clause_popcount.sv | 20 ++
 rtl/break_mask_fetch.sv | 115 +++++++++++
 tb/tb_break_mask_fetch.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/break_mask_fetch_pkg.sv
// Shared definitions for the flip-evaluation path: default table widths,
// the fetch FSM state encoding and the break-count width helper.
package sat_pkg;

    // Default widths, shared with the ATT loader so both sides agree on layout
    localparam int DEF_CLAUSE_COUNT               = 20;
    localparam int DEF_VARIABLE_ADDRESS_WIDTH     = 11;
    localparam int DEF_CLAUSE_TABLE_ADDRESS_WIDTH = 11;

    // Fetch FSM state encoding (3-bit)
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ATT_RD   = 3'd1,
        ST_CT_ISSUE = 3'd2,
        ST_CT_WAIT  = 3'd3,
        ST_OUT      = 3'd4
    } bmf_state_e;

    // Width needed to hold a count from 0 up to and including n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/break_mask_fetch_if.sv
// Request/ATT/clause-table/result signal bundle for break_mask_fetch.
// The slave modport is the fetch block; master is whoever drives it.
interface break_mask_fetch_if
    import sat_pkg::*;
#(
    parameter int CLAUSE_COUNT               = DEF_CLAUSE_COUNT,
    parameter int VARIABLE_ADDRESS_WIDTH     = DEF_VARIABLE_ADDRESS_WIDTH,
    parameter int CLAUSE_TABLE_ADDRESS_WIDTH = DEF_CLAUSE_TABLE_ADDRESS_WIDTH
) ();

    localparam int CNT_W = cnt_width(CLAUSE_COUNT);

    // Literal request from variable selection
    logic                                  lit_valid_i;
    logic                                  lit_ready_o;
    logic [VARIABLE_ADDRESS_WIDTH:0]       lit_i;

    // Address translation table read port
    logic [VARIABLE_ADDRESS_WIDTH:0]       att_rd_addr_o;
    logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] att_addr_i;
    logic [CLAUSE_COUNT-1:0]               att_mask_i;

    // Clause-table read port
    logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] ct_rd_addr_o;
    logic [CLAUSE_COUNT-1:0]               ct_data_i;

    // Break-score result to the comparator
    logic                                  brk_valid_o;
    logic                                  brk_ready_i;
    logic [CLAUSE_COUNT-1:0]               brk_vec_o;
    logic [CNT_W-1:0]                      brk_cnt_o;
    logic [VARIABLE_ADDRESS_WIDTH:0]       brk_lit_o;

    modport slave (
        input  lit_valid_i, lit_i, att_addr_i, att_mask_i, ct_data_i, brk_ready_i,
        output lit_ready_o, att_rd_addr_o, ct_rd_addr_o,
               brk_valid_o, brk_vec_o, brk_cnt_o, brk_lit_o
    );

    modport master (
        output lit_valid_i, lit_i, att_addr_i, att_mask_i, ct_data_i, brk_ready_i,
        input  lit_ready_o, att_rd_addr_o, ct_rd_addr_o,
               brk_valid_o, brk_vec_o, brk_cnt_o, brk_lit_o
    );

endinterface

// File: rtl/break_mask_fetch_clause_popcount.sv
// Combinational population count of a clause break vector.
module clause_popcount
    import sat_pkg::*;
#(
    parameter int CLAUSE_COUNT = DEF_CLAUSE_COUNT,
    localparam int CNT_W       = cnt_width(CLAUSE_COUNT)
) (
    input  logic [CLAUSE_COUNT-1:0] vec,
    output logic [CNT_W-1:0]        count
);

    // Sum every flag; the width holds CLAUSE_COUNT itself, so all-ones cannot wrap
    always_comb begin
        count = '0;
        for (int i = 0; i < CLAUSE_COUNT; i++) begin
            count = count + CNT_W'(vec[i]);
        end
    end

endmodule

// File: rtl/break_mask_fetch.sv
// Break-mask fetch: for one literal, read its ATT entry, fetch the
// clause-table word it points at, mask it into a break vector and count it.
// One request is in flight at a time; results wait for the consumer.
module break_mask_fetch
    import sat_pkg::*;
#(
    parameter int CLAUSE_COUNT               = DEF_CLAUSE_COUNT,
    parameter int VARIABLE_ADDRESS_WIDTH     = DEF_VARIABLE_ADDRESS_WIDTH,
    parameter int CLAUSE_TABLE_ADDRESS_WIDTH = DEF_CLAUSE_TABLE_ADDRESS_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    break_mask_fetch_if.slave  bus
);

    localparam int CNT_W = cnt_width(CLAUSE_COUNT);

    localparam logic [2:0] IDLE     = ST_IDLE;
    localparam logic [2:0] ATT_RD   = ST_ATT_RD;
    localparam logic [2:0] CT_ISSUE = ST_CT_ISSUE;
    localparam logic [2:0] CT_WAIT  = ST_CT_WAIT;
    localparam logic [2:0] OUT      = ST_OUT;

    logic [2:0]                            state;
    logic [2:0]                            next_state;

    logic [VARIABLE_ADDRESS_WIDTH:0]       att_rd_addr_q;
    logic [VARIABLE_ADDRESS_WIDTH:0]       lit_q;
    logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] ct_addr_q;
    logic [CLAUSE_COUNT-1:0]               mask_q;

    logic                                  brk_valid_q;
    logic [CLAUSE_COUNT-1:0]               brk_vec_q;
    logic [CNT_W-1:0]                      brk_cnt_q;
    logic [VARIABLE_ADDRESS_WIDTH:0]       brk_lit_q;

    logic [CLAUSE_COUNT-1:0]               masked_vec;
    logic [CNT_W-1:0]                      masked_cnt;

    // The clause-table word is only meaningful in CT_WAIT; mask it there
    assign masked_vec = bus.ct_data_i & mask_q;

    clause_popcount #(
        .CLAUSE_COUNT (CLAUSE_COUNT)
    ) u_popcount (
        .vec   (masked_vec),
        .count (masked_cnt)
    );

    // Step through the fixed fetch sequence; only IDLE and OUT wait on handshakes
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:     next_state = bus.lit_valid_i ? ATT_RD : IDLE;
            ATT_RD:   next_state = CT_ISSUE;
            CT_ISSUE: next_state = CT_WAIT;
            CT_WAIT:  next_state = OUT;
            OUT:      next_state = bus.brk_ready_i ? IDLE : OUT;
            default:  next_state = IDLE;
        endcase
    end

    // Sequence the request and update the result registers only when the word is in hand
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            att_rd_addr_q <= '0;
            lit_q         <= '0;
            ct_addr_q     <= '0;
            mask_q        <= '0;
            brk_valid_q   <= 1'b0;
            brk_vec_q     <= '0;
            brk_cnt_q     <= '0;
            brk_lit_q     <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (bus.lit_valid_i) begin
                        att_rd_addr_q <= bus.lit_i;
                        lit_q         <= bus.lit_i;
                    end
                end
                CT_ISSUE: begin
                    ct_addr_q <= bus.att_addr_i;
                    mask_q    <= bus.att_mask_i;
                end
                CT_WAIT: begin
                    brk_vec_q   <= masked_vec;
                    brk_cnt_q   <= masked_cnt;
                    brk_lit_q   <= lit_q;
                    brk_valid_q <= 1'b1;
                end
                OUT: begin
                    if (bus.brk_ready_i) begin
                        brk_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The clause table sees the fresh ATT address only in CT_ISSUE; elsewhere hold it
    assign bus.ct_rd_addr_o  = (state == CT_ISSUE) ? bus.att_addr_i : ct_addr_q;

    assign bus.lit_ready_o   = (state == IDLE);
    assign bus.att_rd_addr_o = att_rd_addr_q;
    assign bus.brk_valid_o   = brk_valid_q;
    assign bus.brk_vec_o     = brk_vec_q;
    assign bus.brk_cnt_o     = brk_cnt_q;
    assign bus.brk_lit_o     = brk_lit_q;

endmodule

// File: tb/tb_break_mask_fetch.sv
// Directed testbench for break_mask_fetch with 1-cycle ATT and clause-table models.
module tb_break_mask_fetch;

    localparam int CC   = 20;
    localparam int VAW  = 11;
    localparam int CTAW = 11;

    logic clk;
    logic rst;

    int check_count;
    int error_count;

    logic [CTAW-1:0] att_addr_mem [0:(1<<(VAW+1))-1];
    logic [CC-1:0]   att_mask_mem [0:(1<<(VAW+1))-1];
    logic [CC-1:0]   ct_mem       [0:(1<<CTAW)-1];

    break_mask_fetch_if #(
        .CLAUSE_COUNT               (CC),
        .VARIABLE_ADDRESS_WIDTH     (VAW),
        .CLAUSE_TABLE_ADDRESS_WIDTH (CTAW)
    ) bus ();

    break_mask_fetch #(
        .CLAUSE_COUNT               (CC),
        .VARIABLE_ADDRESS_WIDTH     (VAW),
        .CLAUSE_TABLE_ADDRESS_WIDTH (CTAW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ATT and clause table, both with one cycle of read latency
    always @(posedge clk) begin
        bus.att_addr_i <= att_addr_mem[bus.att_rd_addr_o];
        bus.att_mask_i <= att_mask_mem[bus.att_rd_addr_o];
        bus.ct_data_i  <= ct_mem[bus.ct_rd_addr_o];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Wait (bounded) for brk_valid_o, sampling on falling edges; returns cycles waited
    task automatic waitValid(output int cycles);
        cycles = 0;
        while (bus.brk_valid_o !== 1'b1 && cycles < 12) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Issue one literal, check latency and result, stall the consumer, then release
    task automatic applyStimulus(input string tag, input logic [VAW:0] lit,
                                 input logic [CC-1:0] exp_vec, input int exp_cnt,
                                 input int stall);
        int lat;
        bus.brk_ready_i = (stall == 0);
        bus.lit_i       = lit;
        bus.lit_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.lit_valid_i = 1'b0;
        checkOutput({tag, " busy_ready"}, 32'(bus.lit_ready_o), 32'd0);
        waitValid(lat);
        checkOutput({tag, " latency"}, 32'(lat), 32'd3);
        checkOutput({tag, " vec"}, 32'(bus.brk_vec_o), 32'(exp_vec));
        checkOutput({tag, " cnt"}, 32'(bus.brk_cnt_o), 32'(exp_cnt));
        checkOutput({tag, " lit"}, 32'(bus.brk_lit_o), 32'(lit));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput({tag, " stall_valid"}, 32'(bus.brk_valid_o), 32'd1);
            checkOutput({tag, " stall_ready"}, 32'(bus.lit_ready_o), 32'd0);
            checkOutput({tag, " stall_vec"}, 32'(bus.brk_vec_o), 32'(exp_vec));
            checkOutput({tag, " stall_cnt"}, 32'(bus.brk_cnt_o), 32'(exp_cnt));
            checkOutput({tag, " stall_lit"}, 32'(bus.brk_lit_o), 32'(lit));
        end
        bus.brk_ready_i = 1'b1;
        @(negedge clk);
        checkOutput({tag, " done_valid"}, 32'(bus.brk_valid_o), 32'd0);
        checkOutput({tag, " done_ready"}, 32'(bus.lit_ready_o), 32'd1);
    endtask

    initial begin
        int lat;
        int pulses;
        check_count = 0;
        error_count = 0;

        for (int i = 0; i < (1 << (VAW + 1)); i++) begin
            att_addr_mem[i] = '0;
            att_mask_mem[i] = '0;
        end
        for (int i = 0; i < (1 << CTAW); i++) ct_mem[i] = '0;

        att_addr_mem[12'h005] = 11'h012; att_mask_mem[12'h005] = 20'h0000F;
        ct_mem[11'h012]       = 20'h00005;
        att_addr_mem[12'h100] = 11'h055; att_mask_mem[12'h100] = 20'hFFFFF;
        ct_mem[11'h055]       = 20'hFFFFF;
        att_addr_mem[12'h101] = 11'h056; att_mask_mem[12'h101] = 20'h00000;
        ct_mem[11'h056]       = 20'hABCDE;
        att_addr_mem[12'h802] = 11'h3A0; att_mask_mem[12'h802] = 20'hF0F0F;
        ct_mem[11'h3A0]       = 20'h12345;
        att_addr_mem[12'hFFF] = 11'h7FF; att_mask_mem[12'hFFF] = 20'h80001;
        ct_mem[11'h7FF]       = 20'h80003;

        bus.lit_valid_i = 1'b0;
        bus.lit_i       = '0;
        bus.brk_ready_i = 1'b1;
        rst             = 1'b1;

        // Test 1: reset held two cycles, then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset ready", 32'(bus.lit_ready_o), 32'd1);
        checkOutput("reset valid", 32'(bus.brk_valid_o), 32'd0);
        checkOutput("reset cnt", 32'(bus.brk_cnt_o), 32'd0);
        checkOutput("reset vec", 32'(bus.brk_vec_o), 32'd0);
        checkOutput("reset lit", 32'(bus.brk_lit_o), 32'd0);
        checkOutput("reset att_addr", 32'(bus.att_rd_addr_o), 32'd0);
        @(negedge clk);

        // Test 2: basic result
        applyStimulus("basic", 12'h005, 20'h00005, 2, 0);

        // Test 3: backpressure for 5 cycles
        applyStimulus("stall", 12'h005, 20'h00005, 2, 5);

        // Test 4: extremes and a mixed pattern
        applyStimulus("all_ones", 12'h100, 20'hFFFFF, 20, 0);
        applyStimulus("zero_mask", 12'h101, 20'h00000, 0, 0);
        applyStimulus("mixed", 12'h802, 20'h10305, 5, 1);

        // Test 5: second request pulsed while in ATT_RD is ignored
        bus.brk_ready_i = 1'b1;
        bus.lit_i       = 12'h005;
        bus.lit_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.lit_i       = 12'h101;
        bus.lit_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.lit_valid_i = 1'b0;
        checkOutput("busy att_addr", 32'(bus.att_rd_addr_o), 32'h005);
        waitValid(lat);
        checkOutput("busy latency", 32'(lat), 32'd2);
        checkOutput("busy lit", 32'(bus.brk_lit_o), 32'h005);
        checkOutput("busy vec", 32'(bus.brk_vec_o), 32'h00005);
        checkOutput("busy cnt", 32'(bus.brk_cnt_o), 32'd2);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.brk_valid_o === 1'b1) pulses++;
        end
        checkOutput("busy extra_results", 32'(pulses), 32'd0);
        checkOutput("busy att_addr_after", 32'(bus.att_rd_addr_o), 32'h005);

        // Test 6: reset asserted during CT_WAIT drops the request
        bus.lit_i       = 12'h802;
        bus.lit_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.lit_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst valid", 32'(bus.brk_valid_o), 32'd0);
        checkOutput("midrst ready", 32'(bus.lit_ready_o), 32'd1);
        checkOutput("midrst vec", 32'(bus.brk_vec_o), 32'd0);
        checkOutput("midrst cnt", 32'(bus.brk_cnt_o), 32'd0);
        checkOutput("midrst lit", 32'(bus.brk_lit_o), 32'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.brk_valid_o === 1'b1) pulses++;
        end
        checkOutput("midrst no_result", 32'(pulses), 32'd0);
        applyStimulus("post_rst", 12'hFFF, 20'h80001, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
